// File: rtl/sdram_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_arbiter_pkg : shared types and SDRC field widths for the arbiter |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_GRANTED      = 2'd1,
    ST_REFRESH      = 2'd2,
    ST_REFRESH_WAIT = 2'd3
  } arb_state_e;

  localparam int SDRC_ADDR_W = 21;
  localparam int SDRC_DATA_W = 32;
  localparam int SDRC_DQM_W  = 4;
  localparam int SDRC_LEN_W  = 8;
  localparam int SDRC_CMD_W  = 3;

  localparam logic [SDRC_CMD_W-1:0] REFRESH_CMD = 3'b001;

endpackage
`default_nettype wire

// File: rtl/sdram_arbiter_refresh_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | refresh_timer : auto-refresh interval counter with pending/overrun    |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module refresh_timer
  import sdram_arbiter_pkg::*;
#(
  parameter int INTERVAL_CYCLES = 800
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_done_i,
  input  logic issued_i,
  output logic pending_o,
  output logic overrun_o
);

  localparam int CW = (INTERVAL_CYCLES > 2) ? $clog2(INTERVAL_CYCLES) : 1;
  localparam logic [CW-1:0] c_reload = CW'(INTERVAL_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          w_expire;

  always_comb begin
    w_expire = init_done_i && (cnt_q == '0);

    cnt_d = cnt_q;
    if (init_done_i) begin
      cnt_d = w_expire ? c_reload : (cnt_q - 1'b1);
    end

    // An expiry landing on the issue cycle re-arms pending instead of overrunning.
    pending_d = pending_q;
    if (issued_i) pending_d = 1'b0;
    if (w_expire) pending_d = 1'b1;

    overrun_d = overrun_q | (w_expire & pending_q & ~issued_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= c_reload;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_arbiter : round-robin share of one SDRC command port + refresh  |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int                    NUM_PORTS               = 2,
  parameter int                    REFRESH_INTERVAL_CYCLES = 800,
  parameter logic [SDRC_CMD_W-1:0] REFRESH_CMD_CODE        = REFRESH_CMD
) (
  input  logic                              clk,
  input  logic                              rst_n,

  input  logic [NUM_PORTS-1:0]              req_i,
  output logic [NUM_PORTS-1:0]              grant_o,
  input  logic [NUM_PORTS-1:0]              p_cmd_en_i,
  input  logic [NUM_PORTS*SDRC_CMD_W-1:0]   p_cmd_i,
  input  logic [NUM_PORTS*SDRC_ADDR_W-1:0]  p_addr_i,
  input  logic [NUM_PORTS*SDRC_DQM_W-1:0]   p_dqm_i,
  input  logic [NUM_PORTS*SDRC_DATA_W-1:0]  p_data_i,
  input  logic [NUM_PORTS*SDRC_LEN_W-1:0]   p_data_len_i,
  output logic [NUM_PORTS-1:0]              p_cmd_ack_o,
  output logic [SDRC_DATA_W-1:0]            p_data_out_o,
  output logic                              refresh_overrun_o,

  output logic                              I_sdrc_cmd_en,
  output logic [SDRC_CMD_W-1:0]             I_sdrc_cmd,
  output logic [SDRC_ADDR_W-1:0]            I_sdrc_addr,
  output logic [SDRC_DQM_W-1:0]             I_sdrc_dqm,
  output logic [SDRC_DATA_W-1:0]            I_sdrc_data,
  output logic [SDRC_LEN_W-1:0]             I_sdrc_data_len,

  input  logic [SDRC_DATA_W-1:0]            O_sdrc_data,
  input  logic                              O_sdrc_init_done,
  input  logic                              O_sdrc_cmd_ack
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [NUM_PORTS-1:0] c_one = NUM_PORTS'(1);

  arb_state_e           state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [PW-1:0]        ptr_q;
  logic                 outstanding_q;
  logic                 w_outstanding_d;

  logic                 w_pick_any;
  logic [PW-1:0]        w_pick_idx;
  logic                 w_fwd_en;
  logic                 w_release;
  logic                 w_ref_pending;
  logic                 w_ref_issued;

  logic [SDRC_CMD_W-1:0]  w_cmd  [NUM_PORTS];
  logic [SDRC_ADDR_W-1:0] w_addr [NUM_PORTS];
  logic [SDRC_DQM_W-1:0]  w_dqm  [NUM_PORTS];
  logic [SDRC_DATA_W-1:0] w_data [NUM_PORTS];
  logic [SDRC_LEN_W-1:0]  w_len  [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign w_cmd[gi]  = p_cmd_i[gi*SDRC_CMD_W +: SDRC_CMD_W];
    assign w_addr[gi] = p_addr_i[gi*SDRC_ADDR_W +: SDRC_ADDR_W];
    assign w_dqm[gi]  = p_dqm_i[gi*SDRC_DQM_W +: SDRC_DQM_W];
    assign w_data[gi] = p_data_i[gi*SDRC_DATA_W +: SDRC_DATA_W];
    assign w_len[gi]  = p_data_len_i[gi*SDRC_LEN_W +: SDRC_LEN_W];
  end

  refresh_timer #(
    .INTERVAL_CYCLES (REFRESH_INTERVAL_CYCLES)
  ) u_refresh_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_done_i (O_sdrc_init_done),
    .issued_i    (w_ref_issued),
    .pending_o   (w_ref_pending),
    .overrun_o   (refresh_overrun_o)
  );

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    int            c;
    logic [PW-1:0] cand;
    c          = 0;
    cand       = '0;
    w_pick_any = 1'b0;
    w_pick_idx = ptr_q;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      c = int'(ptr_q) + k;
      if (c >= NUM_PORTS) c = c - NUM_PORTS;
      cand = PW'(c);
      if (!w_pick_any && req_i[cand]) begin
        w_pick_any = 1'b1;
        w_pick_idx = cand;
      end
    end
  end

  assign w_ref_issued    = (state_q == ST_REFRESH);
  assign w_fwd_en        = (state_q == ST_GRANTED) && p_cmd_en_i[ptr_q];
  assign w_outstanding_d = (outstanding_q & ~O_sdrc_cmd_ack) | w_fwd_en;
  assign w_release       = ~req_i[ptr_q] & ~w_outstanding_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      ptr_q         <= PW'(NUM_PORTS - 1);
      outstanding_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          outstanding_q <= 1'b0;
          if (O_sdrc_init_done) begin
            if (w_ref_pending) begin
              state_q <= ST_REFRESH;
            end else if (w_pick_any) begin
              state_q <= ST_GRANTED;
              grant_q <= c_one << w_pick_idx;
              ptr_q   <= w_pick_idx;
            end
          end
        end
        ST_GRANTED: begin
          outstanding_q <= w_outstanding_d;
          if (w_release) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            outstanding_q <= 1'b0;
          end
        end
        ST_REFRESH: begin
          state_q <= ST_REFRESH_WAIT;
        end
        ST_REFRESH_WAIT: begin
          if (O_sdrc_cmd_ack) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    I_sdrc_cmd_en   = 1'b0;
    I_sdrc_cmd      = '0;
    I_sdrc_addr     = '0;
    I_sdrc_dqm      = '0;
    I_sdrc_data     = '0;
    I_sdrc_data_len = '0;
    case (state_q)
      ST_GRANTED: begin
        I_sdrc_cmd_en   = p_cmd_en_i[ptr_q];
        I_sdrc_cmd      = w_cmd[ptr_q];
        I_sdrc_addr     = w_addr[ptr_q];
        I_sdrc_dqm      = w_dqm[ptr_q];
        I_sdrc_data     = w_data[ptr_q];
        I_sdrc_data_len = w_len[ptr_q];
      end
      ST_REFRESH: begin
        I_sdrc_cmd_en = 1'b1;
        I_sdrc_cmd    = REFRESH_CMD_CODE;
      end
      default: ;
    endcase
  end

  // Refresh acks arrive in REFRESH_WAIT and are deliberately not routed.
  assign p_cmd_ack_o  = ((state_q == ST_GRANTED) && O_sdrc_cmd_ack) ? grant_q : '0;
  assign grant_o      = grant_q;
  assign p_data_out_o = O_sdrc_data;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sdram_arbiter : directed self-checking bench for sdram_arbiter     |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, grant, p_cmd_en, p_ack;
  logic [5:0]  p_cmd;
  logic [41:0] p_addr;
  logic [7:0]  p_dqm;
  logic [63:0] p_data;
  logic [15:0] p_len;
  logic [31:0] p_dout;
  logic        overrun;
  logic        sd_cmd_en;
  logic [2:0]  sd_cmd;
  logic [20:0] sd_addr;
  logic [3:0]  sd_dqm;
  logic [31:0] sd_data;
  logic [7:0]  sd_len;
  logic [31:0] sd_rdata;
  logic        init_done, sd_ack;

  int total = 0;
  int bad   = 0;
  int flag;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .NUM_PORTS               (2),
    .REFRESH_INTERVAL_CYCLES (20),
    .REFRESH_CMD_CODE        (3'b001)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_i             (req),
    .grant_o           (grant),
    .p_cmd_en_i        (p_cmd_en),
    .p_cmd_i           (p_cmd),
    .p_addr_i          (p_addr),
    .p_dqm_i           (p_dqm),
    .p_data_i          (p_data),
    .p_data_len_i      (p_len),
    .p_cmd_ack_o       (p_ack),
    .p_data_out_o      (p_dout),
    .refresh_overrun_o (overrun),
    .I_sdrc_cmd_en     (sd_cmd_en),
    .I_sdrc_cmd        (sd_cmd),
    .I_sdrc_addr       (sd_addr),
    .I_sdrc_dqm        (sd_dqm),
    .I_sdrc_data       (sd_data),
    .I_sdrc_data_len   (sd_len),
    .O_sdrc_data       (sd_rdata),
    .O_sdrc_init_done  (init_done),
    .O_sdrc_cmd_ack    (sd_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req = '0; p_cmd_en = '0; p_cmd = '0; p_addr = '0; p_dqm = '0;
    p_data = '0; p_len = '0; sd_rdata = '0; sd_ack = 1'b0;
  endtask

  // Leaves the bench at the negedge just after reset release with init_done high.
  task automatic restart();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    init_done = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    init_done = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    init_done = 1'b0;
    clear_inputs();
    req = 2'b01;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_cmd_en", sd_cmd_en, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_ack", p_ack, 2'b00);

    // init gating
    rst_n = 1'b1;
    flag = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (grant !== 2'b00 || sd_cmd_en !== 1'b0) flag++;
    end
    chk("init_gate_violations", flag, 0);
    init_done = 1'b1;
    @(negedge clk);
    chk("init_grant", grant, 2'b01);

    // pass-through, p1 drives conflicting values that must be ignored
    p_cmd_en = 2'b11;
    p_cmd    = {3'b111, 3'b100};
    p_addr   = {21'h1FFFFF, 21'h00040};
    p_data   = {32'hDEADBEEF, 32'h0000_1234};
    p_dqm    = {4'hF, 4'h0};
    p_len    = {8'hFF, 8'h00};
    sd_rdata = 32'hCAFE_F00D;
    #1;
    chk("pt_cmd_en", sd_cmd_en, 1'b1);
    chk("pt_cmd", sd_cmd, 3'b100);
    chk("pt_addr", sd_addr, 21'h00040);
    chk("pt_data", sd_data, 32'h0000_1234);
    chk("pt_dqm", sd_dqm, 4'h0);
    chk("pt_len", sd_len, 8'h00);
    chk("pt_dout", p_dout, 32'hCAFE_F00D);
    @(negedge clk);
    p_cmd_en = 2'b10;
    sd_ack   = 1'b1;
    #1;
    chk("pt_ack_route", p_ack, 2'b01);
    chk("pt_p1_en_ignored", sd_cmd_en, 1'b0);
    @(negedge clk);
    sd_ack = 1'b0;
    p_cmd_en = 2'b00;

    // round-robin
    restart();
    req = 2'b11;
    @(negedge clk);
    chk("rr_first", grant, 2'b01);
    req = 2'b10;
    @(negedge clk);
    chk("rr_gap", grant, 2'b00);
    @(negedge clk);
    chk("rr_second", grant, 2'b10);
    req = 2'b11;
    @(negedge clk);
    chk("rr_hold_p1", grant, 2'b10);
    req = 2'b01;
    @(negedge clk);
    chk("rr_gap2", grant, 2'b00);
    req = 2'b11;
    @(negedge clk);
    chk("rr_third", grant, 2'b01);

    // outstanding hold
    restart();
    req = 2'b01;
    @(negedge clk);
    chk("os_grant", grant, 2'b01);
    p_cmd_en = 2'b01;
    p_cmd    = 6'b000_101;
    @(negedge clk);
    p_cmd_en = 2'b00;
    req      = 2'b00;
    @(negedge clk);
    chk("os_hold1", grant, 2'b01);
    @(negedge clk);
    chk("os_hold2", grant, 2'b01);
    sd_ack = 1'b1;
    #1;
    chk("os_ack", p_ack, 2'b01);
    @(negedge clk);
    sd_ack = 1'b0;
    chk("os_release", grant, 2'b00);

    // refresh deferral behind a held grant
    restart();
    req = 2'b10;
    @(negedge clk);
    chk("rd_grant_p1", grant, 2'b10);
    req = 2'b11;
    flag = 0;
    for (int i = 2; i <= 25; i++) begin
      @(negedge clk);
      if (grant !== 2'b10 || sd_cmd_en !== 1'b0) flag++;
    end
    chk("rd_no_preempt", flag, 0);
    req = 2'b01;
    @(negedge clk);
    chk("rd_released", grant, 2'b00);
    @(negedge clk);
    #1;
    chk("rd_ref_en", sd_cmd_en, 1'b1);
    chk("rd_ref_cmd", sd_cmd, 3'b001);
    chk("rd_ref_addr", sd_addr, 21'h0);
    chk("rd_ref_nogrant", grant, 2'b00);
    @(negedge clk);
    sd_ack = 1'b1;
    #1;
    chk("rd_wait_en", sd_cmd_en, 1'b0);
    chk("rd_ack_unrouted", p_ack, 2'b00);
    @(negedge clk);
    sd_ack = 1'b0;
    chk("rd_wait_nogrant", grant, 2'b00);
    @(negedge clk);
    chk("rd_p0_after", grant, 2'b01);

    // overrun, then async reset mid-transaction
    restart();
    req = 2'b01;
    @(negedge clk);
    chk("ov_grant", grant, 2'b01);
    for (int i = 2; i <= 39; i++) @(negedge clk);
    chk("ov_before", overrun, 1'b0);
    @(negedge clk);
    chk("ov_set", overrun, 1'b1);
    for (int i = 41; i <= 50; i++) @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ov_ref_en", sd_cmd_en, 1'b1);
    chk("ov_ref_cmd", sd_cmd, 3'b001);
    @(negedge clk);
    sd_ack = 1'b1;
    @(negedge clk);
    sd_ack = 1'b0;
    chk("ov_sticky", overrun, 1'b1);
    req = 2'b01;
    @(negedge clk);
    chk("ov_regrant", grant, 2'b01);
    p_cmd_en = 2'b01;
    p_cmd    = 6'b000_010;
    #1;
    chk("ar_cmd_before", sd_cmd_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ar_cmd_dropped", sd_cmd_en, 1'b0);
    chk("ar_grant", grant, 2'b00);
    chk("ar_overrun", overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
